// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver with a 16x oversampled frame decoder feeding a small
//   byte FIFO. The consumer pops bytes with recv_en. Overflow, framing and
//   parity errors are reported on sticky flags.
//
//   Optional feature macro: UART_PARITY_EN
//     undefined : 8N1 frames, parity_err tied low
//     defined   : 8E1 frames, even parity bit checked after the data bits
//
// Parameters
//   BAUDRATE   line bit rate in bits/s
//   CLOCKRATE  clk frequency in Hz
//   DEPTH      FIFO entries (power of two, >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx          serial input, idle high, asynchronous to clk
//   recv_en     read request from the consumer
//   recv_data   byte returned by the last acknowledged read
//   recv_avail  FIFO holds at least one byte
//   recv_ack    one-cycle pulse: recv_data has just been updated
//   clr_err     clears the sticky error flags
//   overflow    byte dropped because the FIFO was full
//   frame_err   stop bit sampled low
//   parity_err  parity mismatch (parity build only)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int BAUDRATE  = 9600,
   parameter int CLOCKRATE = 100000000,
   parameter int DEPTH     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       recv_en,
   output logic [7:0] recv_data,
   output logic       recv_avail,
   output logic       recv_ack,
   input  logic       clr_err,
   output logic       overflow,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int TICK_DIV_RAW = CLOCKRATE / (BAUDRATE * 16);
   localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
   localparam int CW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW           = $clog2(DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]    state;
   logic [3:0]    os_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic [CW-1:0] div_cnt;
   logic          tick;
   logic          rx_p0, rx_p1, rx_p2;
   logic          start_edge;
   logic          sample_full;
   logic          stop_sample;
   logic          push, pop, wr_ok, ovf_evt, frame_evt, parity_evt;
   logic          par_bad;
   logic          empty, full;
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [7:0]    mem [DEPTH];

   // ---- stage p0/p1: two-flop synchronizer, p2 keeps history for edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   assign start_edge = (state == S_IDLE) && rx_p2 && !rx_p1;

   // Free-running divider; restarted at the start edge so the sample points
   // land in the middle of each bit.
   assign tick = (div_cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt <= '0;
      else if (start_edge || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + CW'(1);
   end

   // A full bit period has elapsed since the previous sample point.
   assign sample_full = tick && (os_cnt == 4'd15);

   // ---- frame decoder
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         os_cnt  <= 4'd0;
         bit_cnt <= 3'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_edge) begin
                  state  <= S_START;
                  os_cnt <= 4'd0;
               end
            end
            S_START: begin
               if (tick) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == 4'd7) begin
                     // Mid start bit: a high line here was only a glitch.
                     os_cnt  <= 4'd0;
                     bit_cnt <= 3'd0;
                     state   <= rx_p1 ? S_IDLE : S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == 4'd15) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_STOP;
`endif
                     end
                  end
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (tick) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == 4'd15)
                     state <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (tick) begin
                  os_cnt <= os_cnt + 4'd1;
                  if (os_cnt == 4'd15)
                     state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Data shift register, LSB arrives first.
   always_ff @(posedge clk) begin
      if (state == S_DATA && sample_full)
         shift <= {rx_p1, shift[7:1]};
   end

`ifdef UART_PARITY_EN
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   assign parity_evt = (state == S_PARITY) && sample_full && (rx_p1 != even_parity(shift));

   // Remembers a parity failure until the stop bit decides the frame's fate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         par_bad <= 1'b0;
      else if (state == S_START)
         par_bad <= 1'b0;
      else if (parity_evt)
         par_bad <= 1'b1;
   end
`else
   assign parity_evt = 1'b0;
   assign par_bad    = 1'b0;
`endif

   assign stop_sample = (state == S_STOP) && sample_full;
   assign push        = stop_sample && rx_p1 && !par_bad;
   assign frame_evt   = stop_sample && !rx_p1;

   // ---- FIFO: extra pointer MSB distinguishes full from empty
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = recv_en && !empty;
   assign wr_ok   = push && (!full || pop);
   assign ovf_evt = push && full && !pop;

   assign recv_avail = !empty;

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr[AW-1:0]] <= shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // ---- stage: read port register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         recv_data <= 8'h00;
         recv_ack  <= 1'b0;
      end else begin
         recv_ack <= pop;
         if (pop)
            recv_data <= mem[rd_ptr[AW-1:0]];
      end
   end

   // ---- sticky flags: a new event wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= ovf_evt   | (overflow  & ~clr_err);
         frame_err <= frame_evt | (frame_err & ~clr_err);
      end
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity_err <= 1'b0;
      else
         parity_err <= parity_evt | (parity_err & ~clr_err);
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo at CLOCKRATE=1600000, BAUDRATE=10000
//   (10 clocks per tick, 160 clocks per bit). Frames are driven bit by bit on
//   rx; a queue-based model of the FIFO and flags supplies expected values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   localparam int DEPTH   = 8;
   localparam int BIT_CLK = 160;
`ifdef UART_PARITY_EN
   localparam int PBIT = 1;
`else
   localparam int PBIT = 0;
`endif
   // Start sample at 8 ticks, one bit (16 ticks) per data/parity/stop bit,
   // plus synchronizer and edge-detect delay.
   localparam int EXP_LAT = 10 * (8 + 16 * (8 + PBIT + 1)) + 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       recv_en;
   logic [7:0] recv_data;
   logic       recv_avail;
   logic       recv_ack;
   logic       clr_err;
   logic       overflow;
   logic       frame_err;
   logic       parity_err;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic [7:0] q[$];
   bit         m_ovf, m_ferr, m_perr;
   logic [7:0] m_last;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .BAUDRATE (10000),
      .CLOCKRATE(1600000),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .recv_en   (recv_en),
      .recv_data (recv_data),
      .recv_avail(recv_avail),
      .recv_ack  (recv_ack),
      .clr_err   (clr_err),
      .overflow  (overflow),
      .frame_err (frame_err),
      .parity_err(parity_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected effect of one complete frame on FIFO contents and flags.
   task automatic model_frame(input logic [7:0] b, input bit stop, input bit par_ok);
      if (!par_ok) m_perr = 1'b1;
      if (!stop)   m_ferr = 1'b1;
      if (stop && par_ok) begin
         if (q.size() < DEPTH) q.push_back(b);
         else                  m_ovf = 1'b1;
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
      m_last = 8'h00;
   endtask

   // Drive one frame on rx, then a short idle gap.
   task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_ok);
      rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLK) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rx = (^b) ^ ~par_ok;
      repeat (BIT_CLK) @(negedge clk);
`endif
      rx = stop;
      repeat (BIT_CLK) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic send_and_model(input logic [7:0] b, input bit stop, input bit par_ok);
      send_frame(b, stop, par_ok);
      model_frame(b, stop, par_ok);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_avail"},  recv_avail, (q.size() != 0));
      chk({tag, "_ovf"},    overflow,   m_ovf);
      chk({tag, "_ferr"},   frame_err,  m_ferr);
      chk({tag, "_perr"},   parity_err, m_perr);
   endtask

   // Single-cycle read request; empty reads expect no ack and held data.
   task automatic read_one(input string tag);
      logic [7:0] exp_d;
      logic       exp_a;
      if (q.size() > 0) begin
         exp_a  = 1'b1;
         exp_d  = q.pop_front();
         m_last = exp_d;
      end else begin
         exp_a = 1'b0;
         exp_d = m_last;
      end
      @(negedge clk) recv_en = 1'b1;
      @(negedge clk) recv_en = 1'b0;
      chk({tag, "_ack"},  recv_ack,  exp_a);
      chk({tag, "_data"}, recv_data, exp_d);
      @(negedge clk);
      chk({tag, "_ack_drop"}, recv_ack, 1'b0);
   endtask

   // recv_en held high for n cycles: one pop per cycle while bytes remain.
   task automatic read_burst(input string tag, input int n);
      logic [7:0] exp_d;
      logic       exp_a;
      @(negedge clk) recv_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (q.size() > 0) begin
            exp_a  = 1'b1;
            exp_d  = q.pop_front();
            m_last = exp_d;
         end else begin
            exp_a = 1'b0;
            exp_d = m_last;
         end
         @(negedge clk);
         if (i == n - 1) recv_en = 1'b0;
         chk($sformatf("%s%0d_ack", tag, i),  recv_ack,  exp_a);
         chk($sformatf("%s%0d_data", tag, i), recv_data, exp_d);
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  kind_ok;
      rst     = 1'b1;
      rx      = 1'b1;
      recv_en = 1'b0;
      clr_err = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_avail", recv_avail, 1'b0);
      chk("rst_ack",   recv_ack,   1'b0);
      chk("rst_data",  recv_data,  8'h00);
      chk("rst_flags", {overflow, frame_err, parity_err}, 3'b000);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // 0x5A: arrival latency, single-ack read, FIFO drains
      lat = 0;
      fork
         send_frame(8'h5A, 1'b1, 1'b1);
         begin
            while (!recv_avail && lat < 3000) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      model_frame(8'h5A, 1'b1, 1'b1);
      kind_ok = (lat >= EXP_LAT - 4) && (lat <= EXP_LAT + 4);
      chk("5a_latency_window", kind_ok, 1'b1);
      check_state("5a");
      read_one("5a_rd");
      chk("5a_empty_after", recv_avail, 1'b0);

      // glitch on the start bit: nothing recorded
      rx = 1'b0;
      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      check_state("glitch");
      send_and_model(8'h3C, 1'b1, 1'b1);
      check_state("3c");
      read_one("3c_rd");

      // framing error, then clear
      send_and_model(8'hFF, 1'b0, 1'b1);
      check_state("ferr");
      pulse_clr();
      @(negedge clk);
      check_state("ferr_clr");

      // overflow: nine bytes into eight entries
      for (int i = 0; i < 9; i++)
         send_and_model(8'(i), 1'b1, 1'b1);
      check_state("ovf");
      read_burst("ovf_rd", 8);
      @(negedge clk);
      check_state("ovf_drained");
      read_one("empty_rd");
      pulse_clr();

      // reset mid-frame with non-reset state present beforehand
      send_and_model(8'h11, 1'b1, 1'b1);
      send_and_model(8'h22, 1'b0, 1'b1);
      check_state("pre_rst");
      fork
         send_frame(8'h81, 1'b1, 1'b1);
         begin
            repeat (BIT_CLK * 5 + BIT_CLK / 2) @(negedge clk);
            rst = 1'b1;
            repeat (5) @(negedge clk);
            model_reset();
            chk("midrst_avail", recv_avail, 1'b0);
            chk("midrst_ack",   recv_ack,   1'b0);
            chk("midrst_data",  recv_data,  8'h00);
            chk("midrst_flags", {overflow, frame_err, parity_err}, 3'b000);
            // release during bit 7 of 0x81, where the line is high
            repeat (BIT_CLK * 3 - 5) @(negedge clk);
            rst = 1'b0;
         end
      join
      check_state("post_rst");
      send_and_model(8'hA5, 1'b1, 1'b1);
      check_state("a5");
      read_one("a5_rd");

`ifdef UART_PARITY_EN
      send_and_model(8'h03, 1'b1, 1'b0);
      check_state("par_bad");
      pulse_clr();
      send_and_model(8'h03, 1'b1, 1'b1);
      check_state("par_good");
      read_one("par_rd");
`endif

      // randomized frames, errors, reads and clears
      for (int f = 0; f < 12; f++) begin
         logic [7:0] b;
         int         kind;
         bit         stop_ok, par_ok;
         b       = 8'($urandom);
         kind    = $urandom_range(0, 7);
         stop_ok = (kind != 0);
         par_ok  = (PBIT == 0) || (kind != 1);
         send_and_model(b, stop_ok, par_ok);
         check_state($sformatf("rnd%0d", f));
         for (int r = $urandom_range(0, 2); r > 0; r--)
            read_one($sformatf("rnd%0d_rd", f));
         if ($urandom_range(0, 3) == 0) pulse_clr();
      end
      read_burst("final_rd", DEPTH + 1);
      @(negedge clk);
      check_state("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
